// File: rtl/color_draw_scheduler_if.sv
// Request/grant bundle between the game FSM (master) and the color draw scheduler (slave).
// One level request per platform slot plus the ball, with one-cycle ack pulses and the granted color.
interface color_draw_scheduler_if #(
  parameter int IDX_W = 2
);
  localparam int N_PLAT = 2 ** IDX_W;

  logic [N_PLAT-1:0] plat_req;
  logic              ball_req;
  logic [N_PLAT-1:0] plat_ack;
  logic              ball_ack;
  logic [2:0]        color_out;

  modport master (
    output plat_req,
    output ball_req,
    input  plat_ack,
    input  ball_ack,
    input  color_out
  );

  modport slave (
    input  plat_req,
    input  ball_req,
    output plat_ack,
    output ball_ack,
    output color_out
  );
endinterface

// File: rtl/color_draw_scheduler.sv
// Shares one pseudo_rand generator between the platform slots and the ball, rejecting black
// or repeated platform colors, and keeps the live platform color table.
module color_draw_scheduler #(
  parameter int IDX_W     = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  color_draw_scheduler_if.slave       bus,
  input  logic [7:0]                  rand_in,
  output logic                        rand_step,
  output logic [3*(2**IDX_W)-1:0]     plat_colors
);
  localparam int N_PLAT = 2 ** IDX_W;
  localparam int RW     = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, STEP, DRAW, GRANT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                is_ball_q, is_ball_d;
  logic [RW-1:0]       retry_cnt_q, retry_cnt_d;
  logic                rand_step_q, rand_step_d;
  logic [N_PLAT-1:0]   plat_ack_q, plat_ack_d;
  logic                ball_ack_q, ball_ack_d;
  logic [2:0]          color_q, color_d;
  logic [3*N_PLAT-1:0] colors_q, colors_d;

  logic [IDX_W-1:0]    rr_pick, rr_probe;
  logic                rr_found;
  logic [IDX_W-1:0]    ball_idx, ball_probe;
  logic [2:0]          ball_color;
  logic                ball_found;
  logic [2:0]          cand, cur_color, plat_color;
  logic                reject;
  logic                unused_rand;

  assign unused_rand = ^rand_in[7:4];

  // First requesting slot at or above rr_ptr, wrapping around the table.
  always_comb begin
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    rr_probe = '0;
    for (int i = 0; i < N_PLAT; i++) begin
      rr_probe = rr_ptr_q + IDX_W'(i);
      if (!rr_found && bus.plat_req[rr_probe]) begin
        rr_pick  = rr_probe;
        rr_found = 1'b1;
      end
    end
  end

  // Ball copies the first live platform color from a random start slot; white if none is live.
  always_comb begin
    ball_idx   = rand_in[IDX_W-1:0];
    ball_color = 3'b111;
    ball_found = 1'b0;
    ball_probe = '0;
    for (int i = 0; i < N_PLAT; i++) begin
      ball_probe = ball_idx + IDX_W'(i);
      if (!ball_found && (colors_q[int'(ball_probe)*3 +: 3] != 3'b000)) begin
        ball_color = colors_q[int'(ball_probe)*3 +: 3];
        ball_found = 1'b1;
      end
    end
  end

  always_comb begin
    cand       = rand_in[3:1];
    cur_color  = colors_q[int'(winner_q)*3 +: 3];
    reject     = (cand == 3'b000) || (cand == cur_color);
    plat_color = reject ? 3'b111 : cand;
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    is_ball_d   = is_ball_q;
    retry_cnt_d = retry_cnt_q;
    rand_step_d = 1'b0;
    plat_ack_d  = '0;
    ball_ack_d  = 1'b0;
    color_d     = color_q;
    colors_d    = colors_q;
    case (state_q)
      IDLE: begin
        if (bus.ball_req) begin
          is_ball_d   = 1'b1;
          retry_cnt_d = '0;
          rand_step_d = 1'b1;
          state_d     = STEP;
        end else if (|bus.plat_req) begin
          is_ball_d   = 1'b0;
          winner_d    = rr_pick;
          retry_cnt_d = '0;
          rand_step_d = 1'b1;
          state_d     = STEP;
        end
      end
      STEP: state_d = DRAW;
      DRAW: begin
        if (is_ball_q) begin
          color_d    = ball_color;
          ball_ack_d = 1'b1;
          state_d    = GRANT;
        end else if (reject && (retry_cnt_q < RW'(MAX_RETRY))) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          rand_step_d = 1'b1;
          state_d     = STEP;
        end else begin
          // Out of retries the fallback white is taken even if it repeats the slot's color.
          color_d                             = plat_color;
          colors_d[int'(winner_q)*3 +: 3]     = plat_color;
          plat_ack_d[winner_q]                = 1'b1;
          rr_ptr_d                            = winner_q + 1'b1;
          state_d                             = GRANT;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      is_ball_q   <= 1'b0;
      retry_cnt_q <= '0;
      rand_step_q <= 1'b0;
      plat_ack_q  <= '0;
      ball_ack_q  <= 1'b0;
      color_q     <= 3'b000;
      colors_q    <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      is_ball_q   <= is_ball_d;
      retry_cnt_q <= retry_cnt_d;
      rand_step_q <= rand_step_d;
      plat_ack_q  <= plat_ack_d;
      ball_ack_q  <= ball_ack_d;
      color_q     <= color_d;
      colors_q    <= colors_d;
    end
  end

  assign rand_step     = rand_step_q;
  assign plat_colors   = colors_q;
  assign bus.plat_ack  = plat_ack_q;
  assign bus.ball_ack  = ball_ack_q;
  assign bus.color_out = color_q;
endmodule

// File: tb/tb_color_draw_scheduler.sv
// Scoreboard bench for color_draw_scheduler: a stand-in generator feeds chosen draws, a reference
// model predicts each grant, and a monitor checks every ack plus the held outputs between acks.
module tb_color_draw_scheduler;
  localparam int N    = 4;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rand_in;
  logic        rand_step;
  logic [11:0] plat_colors;

  color_draw_scheduler_if #(.IDX_W(2)) bus ();

  color_draw_scheduler #(.IDX_W(2), .MAX_RETRY(MAXR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .rand_in     (rand_in),
    .rand_step   (rand_step),
    .plat_colors (plat_colors)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isBall;
    int          slot;
    logic [2:0]  color;
    logic [11:0] tbl;
    int          ackCycle;
    int          steps;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  randQ[$];
  logic [7:0]  directedDraws[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [2:0]  mTable[N];
  int          mRr;
  logic [N-1:0] pendMask;
  bit          pendBall;
  int          stepCnt = 0;
  logic [2:0]  lastColor = 3'b000;
  logic [11:0] lastTable = 12'h000;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for pseudo_rand: each step presents the next planned draw.
  always @(posedge clk) begin
    if (reset) rand_in <= 8'h00;
    else if (rand_step) begin
      if (randQ.size() > 0) rand_in <= randQ.pop_front();
      else rand_in <= 8'h5A;
    end
  end

  task automatic checkOutput(input string name, input longint got, input longint expected);
    checks++;
    if (got != expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expected, cyc);
    end
  endtask

  task automatic nextDraw(input logic [2:0] cur, output logic [7:0] v);
    if (directedDraws.size() > 0) v = directedDraws.pop_front();
    else begin
      v = 8'($urandom);
      case ($urandom_range(0, 3))
        0: v[3:1] = 3'b000;
        1: v[3:1] = cur;
        default: ;
      endcase
    end
    randQ.push_back(v);
  endtask

  // Reference model: decides the winner and replays the draw rules for one transaction.
  task automatic predictOne(input int startCyc, output int w);
    exp_t       e;
    logic [7:0] v;
    logic [2:0] cand;
    int         retry;
    int         idx;
    bit         done;
    e.steps = 0;
    w = -1;
    if (pendBall) begin
      nextDraw(3'b000, v);
      e.steps  = 1;
      idx      = int'(v[1:0]);
      e.color  = 3'b111;
      for (int i = N - 1; i >= 0; i--)
        if (mTable[(idx + i) % N] != 3'b000) e.color = mTable[(idx + i) % N];
      e.isBall = 1'b1;
      e.slot   = -1;
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (pendMask[(mRr + i) % N]) w = (mRr + i) % N;
      retry = 0;
      done  = 1'b0;
      do begin
        nextDraw(mTable[w], v);
        e.steps++;
        cand = v[3:1];
        if (cand != 3'b000 && cand != mTable[w]) begin
          e.color = cand;
          done = 1'b1;
        end else if (retry == MAXR) begin
          e.color = 3'b111;
          done = 1'b1;
        end else retry++;
      end while (!done);
      e.isBall  = 1'b0;
      e.slot    = w;
      mTable[w] = e.color;
      mRr       = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) e.tbl[3*i +: 3] = mTable[i];
    e.ackCycle = startCyc + 1 + 2 * e.steps;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.plat_req = '0;
    bus.ball_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    randQ.delete();
    expQ.delete();
    for (int i = 0; i < N; i++) mTable[i] = 3'b000;
    mRr = 0;
  endtask

  // Must be called at a negedge with the DUT idle; serves the whole batch of requests.
  task automatic applyStimulus(input logic [N-1:0] mask, input bit ball, input bit earlyDrop);
    int w;
    bit got;
    pendMask = mask;
    pendBall = ball;
    predictOne(cyc, w);
    bus.plat_req = mask;
    bus.ball_req = ball;
    while (pendMask != 0 || pendBall) begin
      if (earlyDrop) begin
        @(negedge clk);
        bus.plat_req = '0;
        bus.ball_req = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk);
        if (bus.ball_ack || (bus.plat_ack != 0)) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("[TB] FAIL ack_timeout got=none expected=ack for slot %0d", w);
        pendMask = '0;
        pendBall = 1'b0;
        doReset();
      end else begin
        if (w < 0) begin
          bus.ball_req = 1'b0;
          pendBall = 1'b0;
        end else begin
          bus.plat_req[w] = 1'b0;
          pendMask[w] = 1'b0;
        end
        if (pendMask != 0 || pendBall) predictOne(cyc + 1, w);
      end
    end
  endtask

  // Monitor: every ack is matched against the scoreboard; between acks outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stepCnt   = 0;
      lastColor = 3'b000;
      lastTable = 12'h000;
    end else begin
      if (rand_step) stepCnt++;
      if (bus.ball_ack || (bus.plat_ack != 0)) begin
        checkOutput("one_ack", $countones({bus.ball_ack, bus.plat_ack}), 1);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ack got=%b expected=no ack", {bus.ball_ack, bus.plat_ack});
        end else begin
          e = expQ.pop_front();
          checkOutput("ack_code", {bus.ball_ack, bus.plat_ack},
                      e.isBall ? 5'b10000 : 5'(1 << e.slot));
          checkOutput("color_out", bus.color_out, e.color);
          checkOutput("plat_colors", plat_colors, e.tbl);
          checkOutput("ack_cycle", cyc, e.ackCycle);
          checkOutput("step_count", stepCnt, e.steps);
          lastColor = e.color;
          lastTable = e.tbl;
        end
        stepCnt = 0;
      end else begin
        checkOutput("color_hold", bus.color_out, lastColor);
        checkOutput("table_hold", plat_colors, lastTable);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] mask;
    bit ball;
    reset = 1'b1;
    bus.plat_req = '0;
    bus.ball_req = 1'b0;
    mRr = 0;
    for (int i = 0; i < N; i++) mTable[i] = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ack", {bus.ball_ack, bus.plat_ack}, 0);
    checkOutput("reset_step", rand_step, 0);
    checkOutput("reset_color", bus.color_out, 0);
    checkOutput("reset_table", plat_colors, 0);

    $display("[TB] T1 single platform draw");
    directedDraws.push_back(8'h0A);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] T2 two black rejects then accept");
    directedDraws.push_back(8'h00);
    directedDraws.push_back(8'h01);
    directedDraws.push_back(8'h0C);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] T3 retries exhausted, white fallback");
    repeat (4) directedDraws.push_back(8'h00);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] request dropped before ack still completes");
    applyStimulus(4'b1000, 1'b0, 1'b1);
    @(negedge clk);

    $display("[TB] T6 reset during DRAW");
    randQ.push_back(8'h0A);
    bus.plat_req = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.plat_req = '0;
    @(negedge clk);
    checkOutput("t6_ack", {bus.ball_ack, bus.plat_ack}, 0);
    checkOutput("t6_step", rand_step, 0);
    checkOutput("t6_table", plat_colors, 0);
    reset = 1'b0;
    randQ.delete();
    for (int i = 0; i < N; i++) mTable[i] = 3'b000;
    mRr = 0;
    repeat (4) @(negedge clk);

    $display("[TB] T4 all slots held, round robin");
    applyStimulus(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] T5 ball priority and ball color pick");
    doReset();
    @(negedge clk);
    directedDraws.push_back(8'h06);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    directedDraws.push_back(8'h01);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    doReset();
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    $display("[TB] randomized batches");
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if (n % 20 == 19) begin
        doReset();
        @(negedge clk);
      end
      mask = 4'($urandom);
      ball = ($urandom_range(0, 4) == 0);
      if (mask == 0 && !ball) mask = 4'(1 << $urandom_range(0, 3));
      applyStimulus(mask, ball, 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_drain", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
